// File: rtl/tlc_pkg.sv
// Shared encodings, default phase durations and the duration lookup.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tlc_pkg;

  // Phase / light encoding. Lights never show ST_ALL_RED.
  typedef enum logic [1:0] {
    ST_RED     = 2'b00,
    ST_YELLOW  = 2'b01,
    ST_GREEN   = 2'b10,
    ST_ALL_RED = 2'b11
  } phase_e;

  localparam int unsigned T_GREEN_DEF  = 15;
  localparam int unsigned T_YELLOW_DEF = 3;
  localparam int unsigned T_ALLRED_DEF = 1;
  localparam int unsigned T_WALK_DEF   = 10;

  // Ticks loaded on entry to a phase. RED is never a controller phase,
  // so it shares the all-red clearance time.
  function automatic int unsigned duration(input phase_e st,
                                           input int unsigned t_green,
                                           input int unsigned t_yellow,
                                           input int unsigned t_allred);
    case (st)
      ST_GREEN:  return t_green;
      ST_YELLOW: return t_yellow;
      default:   return t_allred;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Control/status bundle of the phase controller (mode-mux side = master).
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or one-cycle strobes.
// Optional pedestrian signals ped_req/walk exist only with TLC_PED_EN.
interface traffic_phase_ctrl_if #(
  parameter int N_DIR = 2,
  parameter int TW    = 5
);
  logic               enb;
  logic               sync_load;
  logic [1:0]         sync_dir;
  logic [1:0]         sync_state;
  logic [N_DIR-1:0]   queue;
  logic [2*N_DIR-1:0] light;
  logic [TW-1:0]      light_time;
  logic [1:0]         cur_dir;
  logic [1:0]         cur_state;
  logic               phase_done;
  logic               tick;
`ifdef TLC_PED_EN
  logic               ped_req;
  logic               walk;

  modport master (output enb, sync_load, sync_dir, sync_state, queue, ped_req,
                  input  light, light_time, cur_dir, cur_state, phase_done, tick, walk);
  modport slave  (input  enb, sync_load, sync_dir, sync_state, queue, ped_req,
                  output light, light_time, cur_dir, cur_state, phase_done, tick, walk);
`else
  modport master (output enb, sync_load, sync_dir, sync_state, queue,
                  input  light, light_time, cur_dir, cur_state, phase_done, tick);
  modport slave  (input  enb, sync_load, sync_dir, sync_state, queue,
                  output light, light_time, cur_dir, cur_state, phase_done, tick);
`endif
endinterface

// File: rtl/tlc_tick_gen.sv
// 1 s prescaler: tick is high for the cycle where the count equals CLK_HZ-1.
// Latency: first tick CLK_HZ-1 cycles after en rises.
// Backpressure: none; count held at 0 while en=0.
// Ports: clk, rst_n (sync, active-low), en (count enable), tick (strobe out).
module tlc_tick_gen #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  if (CLK_HZ < 2) begin : g_clk_hz_err
    $error("CLK_HZ must be at least 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin multi-approach phase controller: GREEN -> YELLOW -> ALL_RED per direction.
// Latency: state/countdown change on the edge that samples tick; outputs one clock later.
// Backpressure: none; enb=0 freezes the countdown and allows sync_load hand-over.
// Ports: clk, rst_n (sync, active-low), bus (traffic_phase_ctrl_if.slave: enb, sync_*,
//   queue in; light, light_time, cur_dir, cur_state, phase_done, tick out).
// Optional macro TLC_PED_EN adds ped_req/walk and an internal WALK phase after ALL_RED.
module traffic_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned N_DIR    = 2,
  parameter int unsigned TW       = 5,
  parameter int unsigned T_GREEN  = T_GREEN_DEF,
  parameter int unsigned T_YELLOW = T_YELLOW_DEF,
  parameter int unsigned T_ALLRED = T_ALLRED_DEF,
  parameter int unsigned T_WALK   = T_WALK_DEF
) (
  input logic           clk,
  input logic           rst_n,
  traffic_phase_ctrl_if.slave bus
);
  localparam logic [TW-1:0] D_GREEN  = TW'(T_GREEN);
  localparam logic [TW-1:0] D_YELLOW = TW'(T_YELLOW);
  localparam logic [TW-1:0] D_ALLRED = TW'(T_ALLRED);
  localparam logic [TW-1:0] D_WALK   = TW'(T_WALK);

  if (N_DIR < 2 || N_DIR > 4) begin : g_ndir_err
    $error("N_DIR must be in 2..4");
  end
  if (T_GREEN >= (1 << TW) || T_YELLOW >= (1 << TW) || T_ALLRED >= (1 << TW)) begin : g_tw_err
    $error("phase durations do not fit in TW bits");
  end

  logic [1:0]       st_q;
  logic [1:0]       dir_q;
  logic [TW-1:0]    lt_q;
  logic             done_q;
  logic             tick;
  logic             expire;
  logic             others;
  logic             enter_walk;
  logic [1:0]       nxt_dir;
  logic [N_DIR-1:0] own_bit;
  logic [TW-1:0]    sync_lt;

  tlc_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (bus.enb),
    .tick (tick)
  );

  // A count of 0 can only arrive via odd parameters; treat it like 1.
  assign expire  = (lt_q <= TW'(1));
  assign own_bit = N_DIR'(1) << dir_q;
  assign others  = |(bus.queue & ~own_bit);
  assign sync_lt = TW'(duration(phase_e'(bus.sync_state), T_GREEN, T_YELLOW, T_ALLRED));

  // First demanding approach cyclically after dir_q (dir_q itself last);
  // the loop runs far-to-near so the nearest hit wins.
  always_comb begin
    int j;
    nxt_dir = 2'((int'(dir_q) + 1) % int'(N_DIR));
    for (int k = int'(N_DIR); k >= 1; k--) begin
      j = (int'(dir_q) + k) % int'(N_DIR);
      if (bus.queue[j]) nxt_dir = 2'(j);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_ALL_RED;
      dir_q  <= 2'(N_DIR - 1);
      lt_q   <= D_ALLRED;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.enb) begin
        if (bus.sync_load) begin
          dir_q <= (int'(bus.sync_dir) < int'(N_DIR)) ? bus.sync_dir : 2'd0;
          st_q  <= (bus.sync_state == ST_RED) ? ST_ALL_RED : bus.sync_state;
          lt_q  <= sync_lt;
        end
      end else if (tick) begin
        if (!expire) begin
          lt_q <= lt_q - TW'(1);
        end else begin
          done_q <= 1'b1;
          case (st_q)
            ST_GREEN: begin
              if (others) begin
                st_q <= ST_YELLOW;
                lt_q <= D_YELLOW;
              end else begin
                lt_q <= D_GREEN;
              end
            end
            ST_YELLOW: begin
              st_q <= ST_ALL_RED;
              lt_q <= D_ALLRED;
            end
            default: begin
              // WALK is reported as ALL_RED; only the countdown is reloaded.
              if (enter_walk) begin
                lt_q <= D_WALK;
              end else begin
                st_q  <= ST_GREEN;
                dir_q <= nxt_dir;
                lt_q  <= D_GREEN;
              end
            end
          endcase
        end
      end
    end
  end

`ifdef TLC_PED_EN
  if (T_WALK >= (1 << TW)) begin : g_walk_err
    $error("T_WALK does not fit in TW bits");
  end

  logic walk_q;
  logic ped_flag;
  logic walk_entry;

  assign enter_walk = ped_flag && !walk_q;
  assign walk_entry = bus.enb && tick && expire && (st_q == ST_ALL_RED) && enter_walk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      walk_q   <= 1'b0;
      ped_flag <= 1'b0;
    end else begin
      ped_flag <= (ped_flag && !walk_entry) || bus.ped_req;
      if (!bus.enb && bus.sync_load) begin
        walk_q <= 1'b0;
      end else if (bus.enb && tick && expire && st_q == ST_ALL_RED) begin
        walk_q <= enter_walk;
      end
    end
  end

  assign bus.walk = walk_q;
`else
  assign enter_walk = 1'b0;
`endif

  // Only the served approach can show GREEN/YELLOW; ALL_RED leaves all RED.
  always_comb begin
    bus.light = '0;
    for (int d = 0; d < int'(N_DIR); d++) begin
      if (d == int'(dir_q) && (st_q == ST_GREEN || st_q == ST_YELLOW)) begin
        bus.light[2*d +: 2] = st_q;
      end
    end
  end

  assign bus.cur_state  = st_q;
  assign bus.cur_dir    = dir_q;
  assign bus.light_time = lt_q;
  assign bus.phase_done = done_q;
  assign bus.tick       = tick;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: a 2-approach and a 4-approach instance at CLK_HZ=4.
// Expected phase entries are queued when stimulus is applied and popped on each phase_done.
// Pedestrian steps run only when TLC_PED_EN is defined.
module tb_traffic_phase_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  traffic_phase_ctrl_if #(.N_DIR(2), .TW(5)) busa();
  traffic_phase_ctrl_if #(.N_DIR(4), .TW(5)) busb();

  traffic_phase_ctrl #(.CLK_HZ(4), .N_DIR(2), .TW(5)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(busa)
  );
  traffic_phase_ctrl #(.CLK_HZ(4), .N_DIR(4), .TW(5)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(busb)
  );

  localparam int RED = 0, YEL = 1, GRN = 2, ALR = 3;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] dir;
    logic [4:0] lt;
    logic [7:0] light;
    logic       walk;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int o_st(input int sel);
    return (sel == 1) ? int'(busb.cur_state) : int'(busa.cur_state);
  endfunction
  function automatic int o_dir(input int sel);
    return (sel == 1) ? int'(busb.cur_dir) : int'(busa.cur_dir);
  endfunction
  function automatic int o_lt(input int sel);
    return (sel == 1) ? int'(busb.light_time) : int'(busa.light_time);
  endfunction
  function automatic int o_light(input int sel);
    return (sel == 1) ? int'(busb.light) : int'(busa.light);
  endfunction
  function automatic int o_pd(input int sel);
    return (sel == 1) ? int'(busb.phase_done) : int'(busa.phase_done);
  endfunction
  function automatic int o_tick(input int sel);
    return (sel == 1) ? int'(busb.tick) : int'(busa.tick);
  endfunction
`ifdef TLC_PED_EN
  function automatic int o_walk(input int sel);
    return (sel == 1) ? int'(busb.walk) : int'(busa.walk);
  endfunction
`endif

  task automatic push(input string tag, input int st, input int dir, input int lt,
                      input int light, input int walk);
    exp_t e;
    e.st    = 2'(st);
    e.dir   = 2'(dir);
    e.lt    = 5'(lt);
    e.light = 8'(light);
    e.walk  = 1'(walk);
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  // Wait (bounded) for the next phase_done, then compare against the queued entry.
  task automatic expect_phase(input int sel, input int max_cyc, input int exp_ticks,
                              input int exp_cyc);
    exp_t  e;
    string tg;
    int    cyc = 0;
    int    tk  = 0;
    int    got = 0;
    while (got == 0 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (o_tick(sel) != 0) tk++;
      if (o_pd(sel) != 0) got = 1;
    end
    e  = sb.pop_front();
    tg = sb_tag.pop_front();
    chk({tg, " phase_done seen"}, got, 1);
    if (got != 0) begin
      chk({tg, " state"}, o_st(sel), int'(e.st));
      chk({tg, " dir"}, o_dir(sel), int'(e.dir));
      chk({tg, " light_time"}, o_lt(sel), int'(e.lt));
      chk({tg, " light"}, o_light(sel), int'(e.light));
`ifdef TLC_PED_EN
      chk({tg, " walk"}, o_walk(sel), int'(e.walk));
`endif
      if (exp_ticks >= 0) chk({tg, " ticks"}, tk, exp_ticks);
      if (exp_cyc >= 0) chk({tg, " cycles"}, cyc, exp_cyc);
    end
  endtask

  task automatic chk_state(input int sel, input string tag, input int st, input int dir,
                           input int lt, input int light);
    chk({tag, " state"}, o_st(sel), st);
    chk({tag, " dir"}, o_dir(sel), dir);
    chk({tag, " light_time"}, o_lt(sel), lt);
    chk({tag, " light"}, o_light(sel), light);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    busa.enb = 1'b0; busa.sync_load = 1'b0; busa.sync_dir = 2'd0; busa.sync_state = 2'd0;
    busa.queue = 2'b00;
    busb.enb = 1'b0; busb.sync_load = 1'b0; busb.sync_dir = 2'd0; busb.sync_state = 2'd0;
    busb.queue = 4'b0000;
`ifdef TLC_PED_EN
    busa.ped_req = 1'b0;
    busb.ped_req = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset values
    chk_state(0, "reset a", ALR, 1, 1, 0);
    chk("reset a phase_done", o_pd(0), 0);
    chk("reset a tick", o_tick(0), 0);
`ifdef TLC_PED_EN
    chk("reset a walk", o_walk(0), 0);
`endif
    chk_state(1, "reset b", ALR, 3, 1, 0);

    // 4-approach direction search
    rst_b = 1'b1;
    busb.sync_load = 1'b1; busb.sync_dir = 2'd1; busb.sync_state = 2'd3; busb.queue = 4'b0001;
    @(negedge clk);
    busb.sync_load = 1'b0;
    chk_state(1, "b sync allred", ALR, 1, 1, 0);
    busb.enb = 1'b1;
    push("b wrap", GRN, 0, 15, 8'b0000_0010, 0);
    expect_phase(1, 12, 1, 4);

    busb.enb = 1'b0; busb.sync_load = 1'b1; busb.sync_dir = 2'd2; busb.sync_state = 2'd3;
    busb.queue = 4'b1000;
    @(negedge clk);
    busb.sync_load = 1'b0; busb.enb = 1'b1;
    push("b skip", GRN, 3, 15, 8'b1000_0000, 0);
    expect_phase(1, 12, 1, -1);

    busb.enb = 1'b0; busb.sync_load = 1'b1; busb.sync_dir = 2'd3; busb.sync_state = 2'd3;
    busb.queue = 4'b0000;
    @(negedge clk);
    busb.sync_load = 1'b0; busb.enb = 1'b1;
    push("b no demand", GRN, 0, 15, 8'b0000_0010, 0);
    expect_phase(1, 12, 1, -1);
    busb.enb = 1'b0;

    // First tick after enable, then green renewal with no demand
    rst_a = 1'b1;
    busa.enb = 1'b1;
    push("t1 first green", GRN, 0, 15, 8'b0000_0010, 0);
    expect_phase(0, 12, 1, 4);
    push("t1 renew", GRN, 0, 15, 8'b0000_0010, 0);
    expect_phase(0, 68, 15, 60);

    // Demand on the other approach
    busa.queue = 2'b10;
    push("t2 yellow", YEL, 0, 3, 8'b0000_0001, 0);
    expect_phase(0, 68, 15, 60);
    push("t2 allred", ALR, 0, 1, 0, 0);
    expect_phase(0, 20, 3, 12);
    push("t2 green dir1", GRN, 1, 15, 8'b0000_1000, 0);
    expect_phase(0, 8, 1, 4);

    // Freeze while disabled, then hand-over
    busa.enb = 1'b0; busa.queue = 2'b00;
    repeat (6) @(negedge clk);
    chk_state(0, "t4 frozen", GRN, 1, 15, 8'b0000_1000);
    chk("t4 frozen phase_done", o_pd(0), 0);
    chk("t4 frozen tick", o_tick(0), 0);

    busa.sync_load = 1'b1; busa.sync_dir = 2'd3; busa.sync_state = 2'd0;
    @(negedge clk);
    busa.sync_load = 1'b0;
    chk_state(0, "t4 sync clamp", ALR, 0, 1, 0);

    busa.sync_load = 1'b1; busa.sync_dir = 2'd1; busa.sync_state = 2'd1;
    @(negedge clk);
    busa.sync_load = 1'b0;
    chk_state(0, "t4 sync yellow", YEL, 1, 3, 8'b0000_0100);

    busa.enb = 1'b1; busa.sync_load = 1'b1; busa.sync_dir = 2'd0; busa.sync_state = 2'd2;
    @(negedge clk);
    busa.sync_load = 1'b0;
    chk_state(0, "t4 sync ignored", YEL, 1, 3, 8'b0000_0100);
    push("t4 allred", ALR, 1, 1, 0, 0);
    expect_phase(0, 20, 3, 11);
    push("t4 green dir0", GRN, 0, 15, 8'b0000_0010, 0);
    expect_phase(0, 8, 1, 4);

    // Reset in the middle of a running YELLOW
    busa.enb = 1'b0; busa.sync_load = 1'b1; busa.sync_dir = 2'd0; busa.sync_state = 2'd1;
    @(negedge clk);
    busa.sync_load = 1'b0; busa.enb = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5 before reset light_time", o_lt(0), 2);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    chk_state(0, "t5 after reset", ALR, 1, 1, 0);
    chk("t5 after reset phase_done", o_pd(0), 0);
    chk("t5 after reset tick", o_tick(0), 0);
    push("t5 restart green", GRN, 0, 15, 8'b0000_0010, 0);
    expect_phase(0, 8, 1, 4);

`ifdef TLC_PED_EN
    // Pedestrian request during GREEN
    busa.ped_req = 1'b1; busa.queue = 2'b10;
    @(negedge clk);
    busa.ped_req = 1'b0;
    push("t6 yellow", YEL, 0, 3, 8'b0000_0001, 0);
    expect_phase(0, 70, -1, -1);
    push("t6 allred", ALR, 0, 1, 0, 0);
    expect_phase(0, 20, 3, -1);
    push("t6 walk", ALR, 0, 10, 0, 1);
    expect_phase(0, 8, 1, -1);
    push("t6 green dir1", GRN, 1, 15, 8'b0000_1000, 0);
    expect_phase(0, 48, 10, 40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised multi-direction traffic-light phase controller; successor to the single-direction per-mode light sequencer.
- Serves N_DIR approaches round-robin through GREEN → YELLOW → ALL_RED phases.
- Extends green on queue demand.
- Exposes a registered countdown.
- Supports state hand-over from another mode controller while disabled.
- Sits under the top-level mode mux beside the fixed-time and manual modes.

Parameters:
CLK_HZ, 100000000, clock cycles per 1 s tick (≥2)
N_DIR, 2, number of approaches (2..4)
TW, 5, countdown width (bits)
T_GREEN, 15, green duration in ticks
T_YELLOW, 3, yellow duration in ticks
T_ALLRED, 1, all-red clearance in ticks
T_WALK, 10, pedestrian walk duration in ticks (used only with TLC_PED_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, synchronous, active-low
enb  in  1  mode enable; 0 = idle/sync, 1 = running
sync_load  in  1  one-cycle hand-over strobe (honoured only when enb=0)
sync_dir  in  2  direction to resume
sync_state  in  2  phase to resume (tlc_pkg encoding)
queue  in  N_DIR  per-direction vehicle-present sensors (level)
light  out  2*N_DIR  per-direction light; light[2d+:2] = direction d
light_time  out  TW  ticks remaining in current phase
cur_dir  out  2  direction currently served
cur_state  out  2  current phase
phase_done  out  1  one-cycle pulse on every phase expiry
tick  out  1  one-cycle 1 s strobe

Behaviour:
- Encodings: RED=00, YELLOW=01, GREEN=10, ALL_RED=11. For lights, 11 is never driven.
- Prescaler:
  - counts 0..CLK_HZ-1 only while enb=1; held at 0 while enb=0
  - tick=1 for the cycle where count==CLK_HZ-1
- Reset (rst_n=0 at clk edge) values:
  - cur_state=ALL_RED, cur_dir=N_DIR-1, light_time=T_ALLRED
  - light all RED, phase_done=0, tick=0, prescaler=0
- enb=0:
  - Countdown frozen; outputs hold.
  - On sync_load: cur_dir=sync_dir (values ≥N_DIR load 0), cur_state=sync_state, light_time=duration(sync_state). RED input is treated as ALL_RED.
- enb=1 and tick: state updates on the edge that samples tick (outputs change one clock after tick is high).
  - light_time>1: decrement.
  - light_time≤1 (0 is treated as 1): phase expires; phase_done=1 for that cycle.
- Expiry transitions:
  - GREEN:
    - if any queue[j], j≠cur_dir, go to YELLOW, load T_YELLOW
    - else stay GREEN, reload T_GREEN (phase_done still pulses)
  - YELLOW: go to ALL_RED, load T_ALLRED.
  - ALL_RED: go to GREEN, load T_GREEN.
    - cur_dir becomes the first j cyclically after cur_dir with queue[j]=1
    - if none, cur_dir+1 mod N_DIR
- Light decode (combinational from registered state, so glitch-free per edge):
  - direction cur_dir shows GREEN/YELLOW when cur_state is GREEN/YELLOW
  - all others RED
  - all RED in ALL_RED
- Simultaneous events:
  - enb=1 with sync_load: sync_load ignored.
  - enb falling mid-phase: remaining light_time held. Running resumes from held value unless sync_load arrives.
  - queue is sampled only at expiry.
- Widths: T_* must fit TW bits; a violation is an elaboration error.

Optional Feature:
TLC_PED_EN:
- With it: adds ports ped_req (in, 1) and walk (out, 1).
- ped_req is latched into a sticky flag on any cycle.
- At ALL_RED expiry with the flag set, enter WALK (internal state; cur_state reports ALL_RED):
  - all lights RED, walk=1, load T_WALK
  - clear the flag on entry
- WALK expiry proceeds to GREEN with the same direction-selection rule.
- Reset clears the flag and sets walk=0.
- Without it: ports absent, no WALK state.

Decomposition:
- Package tlc_pkg: light/state encodings, the duration(state) function, and the default T_* constants.
- Sub-module tlc_tick_gen (parameter CLK_HZ; ports clk, rst_n, en, tick) holds the prescaler.
- Next-direction search stays inline.

Test Plan:
1. CLK_HZ=4, N_DIR=2, no queue, enb=1 after reset → first tick: ALL_RED expiry, GREEN dir0, light_time=15. After 15 more ticks: GREEN renewed, dir0, phase_done pulse.
2. queue=2'b10 during dir0 GREEN → at expiry YELLOW (3), then ALL_RED (1), then GREEN dir1. Light sequence on dir0 is 10→01→00.
3. N_DIR=4, cur_dir=1, queue=4'b0001 at ALL_RED expiry → cur_dir=0 (wrap-around skips empty dirs 2,3).
4. enb=0, sync_load with dir=1, state=YELLOW → light_time=3, light[3:2]=01. Then enb=1 → countdown 3,2,1, then ALL_RED.
5. rst_n=0 mid-YELLOW with enb=1 → next edge: ALL_RED, cur_dir=N_DIR-1, all RED, prescaler=0.
6. TLC_PED_EN, pulse ped_req during GREEN → after ALL_RED: walk=1 for 10 ticks, lights all RED, then GREEN on the next direction.
